mc_ctrl_fsm: RTL

Multi-cycle main controller for the MIPS-lite core. It sits directly upstream of the ALU. Each cycle it decodes the latched instruction and the current state into the ALU operation code, the operand-select lines and the datapath write enables. It consumes the ALU `zero` and `overflow` flags to resolve `beq` and to suppress `addi` writeback on signed overflow.

---
 rtl/mc_ctrl_fsm.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main controller for the MIPS-lite core.
// Decodes the IR and current state into ALU, operand-select and write-enable controls.
module mc_ctrl_fsm #(
  parameter int unsigned RESET_PC_HOLD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        overflow,
  output logic [2:0]  aluCtr,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  extOp,
  output logic        irWr,
  output logic        pcWr,
  output logic        memRd,
  output logic        memWr,
  output logic        regWr,
  output logic [1:0]  pcSrc,
  output logic        regDst,
  output logic        memToReg,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  localparam int unsigned HOLD_W = 4;
  localparam int unsigned OP_W   = 6;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b001101;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_LUI  = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;

  localparam logic [OP_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [OP_W-1:0] FN_SUBU = 6'b100011;
  localparam logic [OP_W-1:0] FN_SLT  = 6'b101010;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MA     = 4'd3,
    S_MR     = 4'd4,
    S_MWB    = 4'd5,
    S_MS     = 4'd6,
    S_EXE    = 4'd7,
    S_AWB    = 4'd8,
    S_BR     = 4'd9,
    S_JMP    = 4'd10
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_ov;
  logic [31:0]         r_instret;
  logic                w_retire;
  logic [OP_W-1:0]     w_op;
  logic [OP_W-1:0]     w_funct;
  logic                w_r_legal;
  logic                w_unused;

  assign w_op      = instr[31:26];
  assign w_funct   = instr[5:0];
  assign w_r_legal = (w_funct == FN_ADDU) || (w_funct == FN_SUBU) || (w_funct == FN_SLT);
  assign w_unused  = ^instr[25:6];

  assign state   = r_state;
  assign instret = r_instret;

  // State, reset-hold counter, captured overflow and retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RST;
      r_hold    <= '0;
      r_ov      <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_RST && w_next == S_RST) r_hold <= r_hold + HOLD_W'(1);
      if (r_state == S_EXE)        r_ov <= overflow;
      else if (r_state == S_FETCH) r_ov <= 1'b0;
      if (w_retire) r_instret <= r_instret + 32'd1;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    w_next   = S_FETCH;
    w_retire = 1'b0;
    aluCtr   = 3'b000;
    aluSrcA  = 1'b0;
    aluSrcB  = 2'b00;
    extOp    = 2'b00;
    irWr     = 1'b0;
    pcWr     = 1'b0;
    memRd    = 1'b0;
    memWr    = 1'b0;
    regWr    = 1'b0;
    pcSrc    = 2'b00;
    regDst   = 1'b0;
    memToReg = 1'b0;
    illegal  = 1'b0;
    case (r_state)
      S_RST: begin
        if (r_hold >= HOLD_W'(RESET_PC_HOLD - 1)) w_next = S_FETCH;
        else                                       w_next = S_RST;
      end
      S_FETCH: begin
        aluSrcB = 2'b01;
        pcWr    = 1'b1;
        irWr    = 1'b1;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut here
        aluSrcB = 2'b11;
        extOp   = 2'b01;
        case (w_op)
          OP_LW, OP_SW:             w_next = S_MA;
          OP_ORI, OP_ADDI, OP_LUI:  w_next = S_EXE;
          OP_BEQ:                   w_next = S_BR;
          OP_J:                     w_next = S_JMP;
          OP_R: begin
            if (w_r_legal) w_next = S_EXE;
            else           illegal = 1'b1;
          end
          default:                  illegal = 1'b1;
        endcase
      end
      S_MA: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        extOp   = 2'b01;
        w_next  = (w_op == OP_LW) ? S_MR : S_MS;
      end
      S_MR: begin
        memRd  = 1'b1;
        w_next = S_MWB;
      end
      S_MWB: begin
        regWr    = 1'b1;
        memToReg = 1'b1;
        w_retire = 1'b1;
      end
      S_MS: begin
        memWr    = 1'b1;
        w_retire = 1'b1;
      end
      S_EXE: begin
        aluSrcA = 1'b1;
        w_next  = S_AWB;
        case (w_op)
          OP_ORI:  begin aluSrcB = 2'b10; extOp = 2'b00; aluCtr = 3'b010; end
          OP_ADDI: begin aluSrcB = 2'b10; extOp = 2'b01; aluCtr = 3'b011; end
          OP_LUI:  begin aluSrcB = 2'b10; extOp = 2'b10; aluCtr = 3'b101; end
          default: begin
            case (w_funct)
              FN_SUBU: aluCtr = 3'b001;
              FN_SLT:  aluCtr = 3'b100;
              default: aluCtr = 3'b000;
            endcase
          end
        endcase
      end
      S_AWB: begin
        regDst   = (w_op == OP_R);
        regWr    = !((w_op == OP_ADDI) && r_ov);
        w_retire = 1'b1;
      end
      S_BR: begin
        aluSrcA  = 1'b1;
        aluCtr   = 3'b001;
        pcSrc    = 2'b01;
        pcWr     = zero;
        w_retire = 1'b1;
      end
      S_JMP: begin
        pcSrc    = 2'b10;
        pcWr     = 1'b1;
        w_retire = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

endmodule
